kernel_adapter_multichannel: RTL
================================

# kernel_adapter_multichannel

Parametrised kernel adapter for HWPE wrappers. It snoops the valid/ready handshakes of N_IN input streams and N_OUT output streams between the streamer and an accelerated kernel. It counts beats per channel against programmable per-channel thresholds and produces the ready/done/idle flags the engine FSM consumes. It generalises the single-beat adapter: arbitrary channel counts, inputs-per-ready and outputs-per-done windows, all-channel aggregation, a two-state run FSM, and a sticky overrun error.

## Interface
Parameters:
- N_IN, 2, number of snooped input streams (≥1)
- N_OUT, 1, number of snooped output streams (≥1)
- CNT_W, 16, width of every counter and threshold

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  start/restart pulse from engine FSM
- in_valid_i  in  N_IN  input stream valid, one bit per channel
- in_ready_i  in  N_IN  input stream ready, one bit per channel
- out_valid_i  in  N_OUT  output stream valid, one bit per channel
- out_ready_i  in  N_OUT  output stream ready, one bit per channel
- in_thresh_i  in  N_IN*CNT_W  beats per input window, channel i at [i*CNT_W +: CNT_W]
- out_thresh_i  in  N_OUT*CNT_W  beats per output window, same packing
- ready_o  out  1  one-cycle pulse: all input windows complete
- done_o  out  1  one-cycle pulse: all output windows complete
- idle_o  out  1  level: FSM in IDLE
- err_o  out  1  sticky input overrun flag
- in_cnt_o  out  N_IN*CNT_W  live input counters
- out_cnt_o  out  N_OUT*CNT_W  live output counters

## Operation
- A beat on channel c is counted when valid[c] & ready[c] in the same cycle. The adapter never drives stream handshakes.
- FSM states:
  - IDLE to RUN on start_i.
  - RUN to IDLE on the cycle done_o is generated, unless start_i is high in that same cycle.
  - RUN to RUN on start_i, which restarts the run.
- Thresholds are latched per channel on start_i. A latched value of 0 is treated as 1. Threshold inputs are ignored at all other times.
- On start_i: all counters go to 0, err_o clears, and beats in that cycle are discarded.
- In IDLE, counters hold and beats are ignored.
- Input counters (RUN):
  - A channel increments on a beat until it equals its threshold ("met"), then holds.
  - When every input channel is met, or reaches its threshold this cycle, the input window closes: ready_o pulses and all input counters reload.
  - On reload, a channel takes 1 if it had a beat this cycle that was not needed to close the window, and 0 otherwise.
  - A beat on an already-met channel when the window does not close sets err_o; the counter holds.
- Output counters (RUN): identical windowing using out_thresh. The window close generates done_o. Output counters never raise err_o; surplus beats on a met channel are dropped.
- ready_o and done_o may pulse in the same cycle.
- in_cnt_o and out_cnt_o show register values.

## Timing
- Reset values: ready_o=0, done_o=0, idle_o=1, err_o=0, all counters 0, latched thresholds 1, FSM IDLE.
- All outputs are registered, giving one cycle of latency:
  - ready_o and done_o are high in the cycle after the closing handshake.
  - idle_o falls in the cycle after start_i.
  - idle_o rises in the same cycle done_o is high when the FSM leaves RUN.
  - err_o rises in the cycle after the overrun beat.
- Counter values are visible in the cycle after the beat.
- Reset asserted mid-run forces all reset values immediately. Operation resumes in IDLE after release.
- Sustained traffic: back-to-back windows of threshold 1 produce ready_o high on consecutive cycles.
- Counters do not wrap: the maximum reachable value is the threshold, at most 2^CNT_W-1.

## Test plan
- Reset, then start_i with N_IN=2, thresholds {3,1}: ch0 beats at cycles 1,2,3 and ch1 at cycle 2 -> ready_o pulses only at cycle 4; in_cnt returns to {0,0}.
- N_OUT=1, out_thresh=4, 4 output beats -> done_o is a single pulse after the 4th beat, idle_o=1 in the same cycle, and further beats are ignored (out_cnt stays 0).
- in_thresh {2,2}: ch0 receives 3 beats before ch1's first -> err_o=1 and stays set, in_cnt ch0 holds at 2; the next start_i clears err_o.
- Window closes on ch1's 2nd beat while ch0 (already met) beats in the same cycle -> ready_o pulses, ch0 counter=1, ch1 counter=0, err_o=0.
- start_i asserted mid-run with beats present -> counters 0 next cycle, the beats in that cycle are not counted, and new thresholds take effect.
- Threshold 0 on all channels with one beat each -> behaves as threshold 1: ready_o/done_o pulse after every beat cycle.

Source files
------------

// File: rtl/kernel_adapter_multichannel.sv
// Kernel adapter: snoops N_IN input and N_OUT output stream handshakes, counts
// beats per channel against latched windows and raises ready/done/idle/err flags.
module kernel_adapter_multichannel #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [N_IN-1:0]        in_valid_i,
  input  logic [N_IN-1:0]        in_ready_i,
  input  logic [N_OUT-1:0]       out_valid_i,
  input  logic [N_OUT-1:0]       out_ready_i,
  input  logic [N_IN*CNT_W-1:0]  in_thresh_i,
  input  logic [N_OUT*CNT_W-1:0] out_thresh_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   idle_o,
  output logic                   err_o,
  output logic [N_IN*CNT_W-1:0]  in_cnt_o,
  output logic [N_OUT*CNT_W-1:0] out_cnt_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e state_q, state_d;
  logic [N_IN-1:0][CNT_W-1:0]  inCnt_q, inCnt_d, inThr_q, inThr_d;
  logic [N_OUT-1:0][CNT_W-1:0] outCnt_q, outCnt_d, outThr_q, outThr_d;
  logic ready_q, ready_d, done_q, done_d, err_q, err_d;

  logic [N_IN-1:0]  inBeat, inMet, inReach;
  logic [N_OUT-1:0] outBeat, outMet, outReach;
  logic inClose, outClose;

  // A channel is complete if it was already met or reaches its threshold now.
  always_comb begin
    inBeat  = in_valid_i & in_ready_i;
    outBeat = out_valid_i & out_ready_i;
    inMet   = '0;
    inReach = '0;
    outMet   = '0;
    outReach = '0;
    for (int c = 0; c < N_IN; c++) begin
      inMet[c]   = (inCnt_q[c] == inThr_q[c]);
      inReach[c] = !inMet[c] && inBeat[c] && ((inCnt_q[c] + CNT_W'(1)) == inThr_q[c]);
    end
    for (int c = 0; c < N_OUT; c++) begin
      outMet[c]   = (outCnt_q[c] == outThr_q[c]);
      outReach[c] = !outMet[c] && outBeat[c] && ((outCnt_q[c] + CNT_W'(1)) == outThr_q[c]);
    end
    inClose  = &(inMet | inReach);
    outClose = &(outMet | outReach);
  end

  always_comb begin
    state_d  = state_q;
    inCnt_d  = inCnt_q;
    inThr_d  = inThr_q;
    outCnt_d = outCnt_q;
    outThr_d = outThr_q;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    if (start_i) begin
      state_d  = RUN;
      inCnt_d  = '0;
      outCnt_d = '0;
      err_d    = 1'b0;
      for (int c = 0; c < N_IN; c++) begin
        inThr_d[c] = (in_thresh_i[c*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                          : in_thresh_i[c*CNT_W +: CNT_W];
      end
      for (int c = 0; c < N_OUT; c++) begin
        outThr_d[c] = (out_thresh_i[c*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                            : out_thresh_i[c*CNT_W +: CNT_W];
      end
    end else if (state_q == RUN) begin
      ready_d = inClose;
      done_d  = outClose;
      // On reload, only surplus beats on already-met channels carry over.
      for (int c = 0; c < N_IN; c++) begin
        if (inClose) begin
          inCnt_d[c] = (inBeat[c] && inMet[c]) ? CNT_W'(1) : '0;
        end else if (inBeat[c] && !inMet[c]) begin
          inCnt_d[c] = inCnt_q[c] + CNT_W'(1);
        end else if (inBeat[c]) begin
          err_d = 1'b1;
        end
      end
      for (int c = 0; c < N_OUT; c++) begin
        if (outClose) begin
          outCnt_d[c] = (outBeat[c] && outMet[c]) ? CNT_W'(1) : '0;
        end else if (outBeat[c] && !outMet[c]) begin
          outCnt_d[c] = outCnt_q[c] + CNT_W'(1);
        end
      end
      if (outClose) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      inCnt_q  <= '0;
      outCnt_q <= '0;
      for (int c = 0; c < N_IN; c++) inThr_q[c] <= CNT_W'(1);
      for (int c = 0; c < N_OUT; c++) outThr_q[c] <= CNT_W'(1);
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      inCnt_q  <= inCnt_d;
      outCnt_q <= outCnt_d;
      inThr_q  <= inThr_d;
      outThr_q <= outThr_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ready_o   = ready_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign idle_o    = (state_q == IDLE);
  assign in_cnt_o  = inCnt_q;
  assign out_cnt_o = outCnt_q;

endmodule
